// File: rtl/serial_word_transmitter_pkg.sv
// Shared definitions for the serial word transmitter: FSM state encoding,
// default sizing constants shared with the receive side, counter width helper.
package serial_word_transmitter_pkg;

    localparam int DATA_W_DEF     = 16;
    localparam int DEPTH_LOG2_DEF = 6;
    localparam int CLK_DIV_DEF    = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_LOW  = 2'd2,
        ST_HIGH = 2'd3
    } tx_state_e;

    // Width of a counter that runs 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_word_transmitter_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered level and ready flag.
// The head word is always visible on rd_data while level is non-zero.
module sync_fifo
    import serial_word_transmitter_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic                  pop,
    output logic [DATA_W-1:0]     rd_data,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int                  DEPTH      = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] LVL_ONE    = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   level_q;
    logic [DEPTH_LOG2:0]   level_n;
    logic                  ready_q;
    logic                  push;
    logic                  pop_ok;

    assign push   = wr_valid && ready_q;
    assign pop_ok = pop && (level_q != '0);

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        level_n = level_q;
        if (push && !pop_ok)
            level_n = level_q + LVL_ONE;
        else if (!push && pop_ok)
            level_n = level_q - LVL_ONE;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            ready_q <= 1'b1;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)
                rd_ptr <= rd_ptr + PTR_ONE;
            level_q <= level_n;
            ready_q <= (level_n != FULL_LEVEL);
        end
    end

    // NOTE: storage is deliberately not reset; pointers and level alone define what is valid.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    assign rd_data  = mem[rd_ptr];
    assign level    = level_q;
    assign wr_ready = ready_q;

endmodule

// File: rtl/serial_word_transmitter.sv
// Return-path serializer: FIFO-buffered 16-bit words shifted out LSB-first with a divided shift clock.
// Define TX_FRAME_SYNC_EN to add the tx_frame output marking bit 0 of every word.
module serial_word_transmitter
    import serial_word_transmitter_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int CLK_DIV    = CLK_DIV_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic                  tx_req,
    output logic                  tx_clk,
    output logic                  tx_serial,
    output logic                  tx_busy,
`ifdef TX_FRAME_SYNC_EN
    output logic                  tx_frame,
`endif
    output logic [DEPTH_LOG2:0]   fifo_level
);

    localparam int              BIT_W   = cnt_width(DATA_W);
    localparam int              DIV_W   = cnt_width(CLK_DIV);
    localparam logic [BIT_W-1:0] BIT_ONE = BIT_W'(1);
    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

    tx_state_e         state_q, state_n;
    logic [DATA_W-1:0] shift_q, shift_n;
    logic [BIT_W-1:0]  bit_q, bit_n;
    logic [DIV_W-1:0]  div_q, div_n;
    logic              tx_clk_q, tx_clk_n;
    logic              serial_q, serial_n;
    logic              busy_q, busy_n;
`ifdef TX_FRAME_SYNC_EN
    logic              frame_q, frame_n;
`endif

    logic [DATA_W-1:0]   fifo_rd_data;
    logic [DEPTH_LOG2:0] level;
    logic                pop;
    logic                div_last;
    logic                bit_last;
    logic                start_ok;

    sync_fifo #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .pop      (pop),
        .rd_data  (fifo_rd_data),
        .level    (level)
    );

    assign pop      = (state_q == ST_LOAD);
    assign div_last = (div_q == DIV_W'(CLK_DIV - 1));
    assign bit_last = (bit_q == BIT_W'(DATA_W - 1));
    // tx_req is only consulted here, i.e. at word boundaries.
    assign start_ok = tx_req && (level != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        unique case (state_q)
            ST_IDLE: if (start_ok) state_n = ST_LOAD;
            ST_LOAD: state_n = ST_LOW;
            ST_LOW:  if (div_last) state_n = ST_HIGH;
            ST_HIGH: if (div_last) state_n = bit_last ? (start_ok ? ST_LOAD : ST_IDLE) : ST_LOW;
            default: state_n = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, aligned with the state they belong to.
    always_comb begin
        shift_n  = shift_q;
        serial_n = serial_q;
        bit_n    = bit_q;
        div_n    = '0;
        unique case (state_q)
            ST_LOAD: begin
                shift_n  = fifo_rd_data;
                serial_n = fifo_rd_data[0];
                bit_n    = '0;
            end
            ST_LOW: begin
                if (!div_last) div_n = div_q + DIV_ONE;
            end
            ST_HIGH: begin
                if (!div_last) begin
                    div_n = div_q + DIV_ONE;
                end else if (!bit_last) begin
                    bit_n    = bit_q + BIT_ONE;
                    shift_n  = shift_q >> 1;
                    serial_n = shift_q[1];
                end
            end
            default: ;
        endcase
        tx_clk_n = (state_n == ST_HIGH);
        busy_n   = (state_n != ST_IDLE);
`ifdef TX_FRAME_SYNC_EN
        frame_n  = ((state_n == ST_LOW) || (state_n == ST_HIGH)) && (bit_n == '0);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q  <= '0;
            bit_q    <= '0;
            div_q    <= '0;
            tx_clk_q <= 1'b0;
            serial_q <= 1'b0;
            busy_q   <= 1'b0;
`ifdef TX_FRAME_SYNC_EN
            frame_q  <= 1'b0;
`endif
        end else begin
            shift_q  <= shift_n;
            bit_q    <= bit_n;
            div_q    <= div_n;
            tx_clk_q <= tx_clk_n;
            serial_q <= serial_n;
            busy_q   <= busy_n;
`ifdef TX_FRAME_SYNC_EN
            frame_q  <= frame_n;
`endif
        end
    end

    assign tx_clk     = tx_clk_q;
    assign tx_serial  = serial_q;
    assign tx_busy    = busy_q;
    assign fifo_level = level;
`ifdef TX_FRAME_SYNC_EN
    assign tx_frame   = frame_q;
`endif

endmodule

// File: tb/tb_serial_word_transmitter.sv
// Self-checking bench for serial_word_transmitter: directed steps plus random words, checked
// against a word queue and timing derived from bit period / word period arithmetic.
module tb_serial_word_transmitter;

    localparam int DATA_W     = 16;
    localparam int DEPTH_LOG2 = 6;
    localparam int CLK_DIV    = 4;
    localparam int DEPTH      = 1 << DEPTH_LOG2;
    localparam int BIT_P      = 2 * CLK_DIV;
    localparam int WORD_P     = DATA_W * BIT_P + 1;

    logic                clk = 1'b0;
    logic                rst;
    logic [DATA_W-1:0]   wr_data;
    logic                wr_valid;
    logic                wr_ready;
    logic                tx_req;
    logic                tx_clk;
    logic                tx_serial;
    logic                tx_busy;
    logic [DEPTH_LOG2:0] fifo_level;
`ifdef TX_FRAME_SYNC_EN
    logic                tx_frame;
    int                  frame_cycles = 0;
    int                  frame_at_bit0 = 0;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [DATA_W-1:0] expq[$];
    logic [DATA_W-1:0] rx_q[$];
    logic [DATA_W-1:0] acc = '0;
    logic [DATA_W-1:0] w;
    int  nbits = 0;
    logic prev_clk = 1'b0;
    int  rise_cnt = 0;
    int  first_rise = -1;
    int  last_rise = 0;
    int  enq_cyc;
    int  rc;

    serial_word_transmitter #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2),
        .CLK_DIV    (CLK_DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .tx_req     (tx_req),
        .tx_clk     (tx_clk),
        .tx_serial  (tx_serial),
        .tx_busy    (tx_busy),
`ifdef TX_FRAME_SYNC_EN
        .tx_frame   (tx_frame),
`endif
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Receiver model: capture tx_serial on each tx_clk rise, reassemble LSB-first words.
    always @(negedge clk) begin
        if (rst) begin
            nbits    = 0;
            acc      = '0;
            prev_clk = 1'b0;
        end else begin
            if (tx_clk && !prev_clk) begin
                rise_cnt++;
                last_rise = cyc;
                if (first_rise < 0) first_rise = cyc;
`ifdef TX_FRAME_SYNC_EN
                if (nbits == 0 && tx_frame) frame_at_bit0++;
`endif
                acc = {tx_serial, acc[DATA_W-1:1]};
                nbits++;
                if (nbits == DATA_W) begin
                    rx_q.push_back(acc);
                    nbits = 0;
                end
            end
`ifdef TX_FRAME_SYNC_EN
            if (tx_frame) frame_cycles++;
`endif
            prev_clk = tx_clk;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_word(input logic [DATA_W-1:0] d);
        wr_data  = d;
        wr_valid = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget, input string tag);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(rx_q.size() >= n), 32'd1);
    endtask

    task automatic wait_bits(input int nw, input int nb, input int budget, input string tag);
        int k = 0;
        while (!(rx_q.size() == nw && nbits == nb) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(rx_q.size() == nw && nbits == nb), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_data  = '0;
        tx_req   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_tx_clk", 32'(tx_clk), 32'd0);
        check("rst_tx_serial", 32'(tx_serial), 32'd0);
        check("rst_tx_busy", 32'(tx_busy), 32'd0);
        check("rst_fifo_level", 32'(fifo_level), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Single word, latency from enqueue edge to first tx_clk rise.
        tx_req     = 1'b1;
        rc         = rise_cnt;
        first_rise = -1;
        write_word(16'hA5C3);
        enq_cyc = cyc;
        wait_rx(1, 4 * WORD_P, "single_done");
        check("single_word", 32'(rx_q.size() > 0 ? rx_q[0] : '0), 32'h0000A5C3);
        check("single_rises", 32'(rise_cnt - rc), 32'(DATA_W));
        check("single_latency", 32'(first_rise - enq_cyc), 32'(CLK_DIV + 2));
        repeat (CLK_DIV + 3) @(negedge clk);
        check("single_busy_end", 32'(tx_busy), 32'd0);
        check("single_level_end", 32'(fifo_level), 32'd0);
        rx_q.delete();

        // Asynchronous reset while bit 7 is on the line drops the partial word.
        w = DATA_W'($urandom);
        write_word(w);
        wait_bits(0, 7, 4 * WORD_P, "midword_reach_bit7");
        #2 rst = 1'b1;
        #1;
        check("midrst_tx_clk", 32'(tx_clk), 32'd0);
        check("midrst_tx_serial", 32'(tx_serial), 32'd0);
        check("midrst_fifo_level", 32'(fifo_level), 32'd0);
        check("midrst_wr_ready", 32'(wr_ready), 32'd1);
        check("midrst_tx_busy", 32'(tx_busy), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rc  = rise_cnt;
        repeat (200) @(negedge clk);
        check("midrst_no_resend", 32'(rise_cnt - rc), 32'd0);
        check("midrst_no_word", 32'(rx_q.size()), 32'd0);

        // Fill the FIFO with tx_req low; the extra write is dropped.
        tx_req = 1'b0;
        expq.delete();
        for (int i = 0; i < DEPTH; i++) begin
            w = DATA_W'($urandom);
            expq.push_back(w);
            write_word(w);
        end
        rc = rise_cnt;
        check("full_level", 32'(fifo_level), 32'(DEPTH));
        check("full_wr_ready", 32'(wr_ready), 32'd0);
        check("full_busy", 32'(tx_busy), 32'd0);
        write_word(DATA_W'($urandom));
        check("full_overflow_level", 32'(fifo_level), 32'(DEPTH));
        repeat (20) @(negedge clk);
        check("full_no_rises", 32'(rise_cnt - rc), 32'd0);
        check("full_tx_clk_low", 32'(tx_clk), 32'd0);

        // Drain the full FIFO back-to-back: exact span proves there is no idle bit between words.
        first_rise = -1;
`ifdef TX_FRAME_SYNC_EN
        frame_cycles  = 0;
        frame_at_bit0 = 0;
`endif
        tx_req = 1'b1;
        wait_rx(DEPTH, DEPTH * WORD_P + 100, "burst_done");
        for (int i = 0; i < DEPTH; i++)
            check($sformatf("burst_word%0d", i), 32'(i < rx_q.size() ? rx_q[i] : 'x), 32'(expq[i]));
        check("burst_rises", 32'(rise_cnt - rc), 32'(DEPTH * DATA_W));
        check("burst_span", 32'(last_rise - first_rise), 32'((DEPTH - 1) * WORD_P + (DATA_W - 1) * BIT_P));
        repeat (CLK_DIV + 3) @(negedge clk);
        check("burst_level_end", 32'(fifo_level), 32'd0);
        check("burst_busy_end", 32'(tx_busy), 32'd0);
        check("burst_wr_ready", 32'(wr_ready), 32'd1);
`ifdef TX_FRAME_SYNC_EN
        check("frame_cycles", 32'(frame_cycles), 32'(DEPTH * BIT_P));
        check("frame_at_bit0", 32'(frame_at_bit0), 32'(DEPTH));
`endif
        rx_q.delete();
        expq.delete();

        // Drop tx_req during bit 5 of the third word: it completes, the fourth never starts.
        tx_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            w = DATA_W'($urandom);
            expq.push_back(w);
            write_word(w);
        end
        tx_req = 1'b1;
        wait_bits(2, 5, 3 * WORD_P + 50, "drop_reach_bit5");
        tx_req = 1'b0;
        wait_rx(3, 2 * WORD_P, "drop_word3_done");
        repeat (2 * WORD_P) @(negedge clk);
        check("drop_word_count", 32'(rx_q.size()), 32'd3);
        check("drop_word3", 32'(rx_q.size() > 2 ? rx_q[2] : 'x), 32'(expq[2]));
        check("drop_busy", 32'(tx_busy), 32'd0);
        check("drop_level", 32'(fifo_level), 32'd3);
        tx_req = 1'b1;
        wait_rx(6, 4 * WORD_P, "drop_drain_done");
        for (int i = 3; i < 6; i++)
            check($sformatf("drop_drain_word%0d", i), 32'(i < rx_q.size() ? rx_q[i] : 'x), 32'(expq[i]));
        rx_q.delete();
        expq.delete();

        // Random words at random spacing with tx_req held high.
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 2 * WORD_P)) @(negedge clk);
            w = DATA_W'($urandom);
            expq.push_back(w);
            write_word(w);
        end
        wait_rx(12, 13 * WORD_P, "rand_done");
        for (int i = 0; i < 12; i++)
            check($sformatf("rand_word%0d", i), 32'(i < rx_q.size() ? rx_q[i] : 'x), 32'(expq[i]));
        repeat (CLK_DIV + 3) @(negedge clk);
        check("rand_level_end", 32'(fifo_level), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
